irig_timestamp_acc: RTL
=======================

# irig_timestamp_acc

Parametrised IRIG-B timestamp accumulator. It collects the per-bit output of the IRIG frame decoder into the BCD time fields (second, minute, hour, day, year) and the straight-binary-seconds (SBS) field. On frame end it range-checks and converts those fields, then presents one timestamp per frame through a valid/ready handshake with per-field error flags and overrun detection. It sits between the IRIG bit decoder and the timestamp consumer (register bank / event tagger).

## Interface
- SBS_WIDTH, 17: SBS field width; strobes with bit_idx >= SBS_WIDTH are ignored.
- SBS_EN, 1: 0 ignores select 6; ts_sec_day is held at 0 and error bit 5 is never set.
- YEAR_EN, 1: 0 ignores select 5; ts_year is held at 0 and error bit 4 is never set.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ts_select  in  3  field select: 1 second, 2 minute, 3 hour, 4 day, 5 year, 6 SBS; 0 and 7 ignored.
- bit_strobe  in  1  qualifies bit_value/bit_idx/digit_idx for one cycle.
- bit_idx  in  5  BCD fields: [1:0] = bit within digit (weight 1/2/4/8). SBS: bit position.
- digit_idx  in  2  BCD digit: 0 units, 1 tens, 2 hundreds; 3 ignored.
- bit_value  in  1  decoded bit.
- ts_finish  in  1  one-cycle pulse: frame complete.
- ts_abort  in  1  one-cycle pulse: discard the frame in progress.
- ts_ready  in  1  consumer accepts the held timestamp.
- ts_valid  out  1  timestamp held on the outputs.
- ts_second  out  6.
- ts_minute  out  6.
- ts_hour  out  5.
- ts_day  out  9.
- ts_year  out  7.
- ts_sec_day  out  SBS_WIDTH.
- ts_error  out  6  per field: [0] sec, [1] min, [2] hour, [3] day, [4] year, [5] SBS.
- ts_overrun  out  1  one-cycle pulse: an unconsumed timestamp was overwritten.

## Operation
- **Accumulators**
  - Each BCD field has one 4-bit nibble per digit.
  - A strobe ORs bit_value into nibble[digit_idx][bit_idx[1:0]]. OR semantics: a repeated strobe on the same bit is idempotent.
  - SBS: OR bit_value at bit_idx.
- **States**
  - IDLE/ACC: accumulating.
  - CHECK: one cycle, convert and check the staging copy.
  - Always returns to ACC.
- **ts_finish in ACC**
  - Copy all accumulators into staging, clear the accumulators, go to CHECK.
  - A strobe in the same cycle as ts_finish is dropped.
- **ts_abort**
  - Clears the accumulators; no output is produced.
  - Abort together with finish: abort wins, no CHECK.
  - Abort during CHECK: it clears only the new-frame accumulators; CHECK completes.
  - ts_finish during CHECK is ignored.
- **CHECK conversion:** value = units + 10·tens + 100·hundreds, truncated to the output width.
- **CHECK error bit set (any condition) for a field:**
  - any digit nibble > 9;
  - second or minute > 59;
  - hour > 23;
  - day == 0 or day > 366;
  - SBS > 86399.
- Unused high digits (minute/second hundreds, etc.) must be 0, otherwise error.
- Outputs load even when errored.
- **Handshake**
  - The edge leaving CHECK loads the outputs and ts_error and sets ts_valid.
  - ts_valid clears on the edge where ts_ready=1, unless a new load occurs on that same edge.
  - Load while ts_valid=1 and ts_ready=0: overwrite the outputs and pulse ts_overrun for one cycle.
  - Load while ts_ready=1: no overrun.

## Timing
- Reset values: all outputs 0 (ts_valid 0, ts_error 0, ts_overrun 0); accumulators and staging 0; state ACC.
- Latency: ts_finish sampled at edge N → CHECK in N..N+1 → outputs and ts_valid visible after edge N+1 (2 cycles).
- Strobes from edge N+1 onward accumulate into the next frame, including during CHECK.
- Outputs hold stable while ts_valid=1 until accepted or overwritten.
- Reset mid-frame or mid-CHECK: immediate return to the reset state; nothing is emitted.
- Back-to-back finish: the minimum spacing is 2 cycles; a finish during CHECK is ignored.

## Test plan
- **Clean frame:** strobe sec 37, min 59, hour 23, day 366, year 24, SBS 86399; finish; ready=1 → two cycles later ts_valid=1 with those values, ts_error=0, ts_valid drops on the next edge.
- **Range/digit errors:** hour tens=2, units=5 (25) and second units nibble 0xA → ts_error[2]=1 and ts_error[0]=1; other bits 0; ts_hour=25.
- **Day boundary:** day 000 → ts_error[3]=1; day 001 → 0. SBS 86400 → ts_error[5]=1.
- **Overrun:** ready held 0 across two frames → second load overwrites the outputs, ts_overrun pulses once, ts_valid stays 1; then ready=1 for one cycle → ts_valid=0.
- **Abort/finish collision:** strobe minute 12, abort and finish in the same cycle → no ts_valid. The next frame with minute 5 yields ts_minute=5, proving the accumulators were cleared.
- **Parameters and reset:** YEAR_EN=0, SBS_WIDTH=10 → year strobes ignored, ts_year=0, SBS bit 12 ignored. Assert rst one cycle after finish → no ts_valid and all outputs 0.

Source files
------------

// File: rtl/irig_timestamp_acc.sv
// IRIG-B timestamp accumulator: gathers decoder bit strobes into BCD and SBS fields,
// range-checks them once per frame and holds the result behind a valid/ready handshake.
module irig_timestamp_acc #(
  parameter int SBS_WIDTH = 17,
  parameter bit SBS_EN    = 1'b1,
  parameter bit YEAR_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           ts_select,
  input  logic                 bit_strobe,
  input  logic [4:0]           bit_idx,
  input  logic [1:0]           digit_idx,
  input  logic                 bit_value,
  input  logic                 ts_finish,
  input  logic                 ts_abort,
  input  logic                 ts_ready,
  output logic                 ts_valid,
  output logic [5:0]           ts_second,
  output logic [5:0]           ts_minute,
  output logic [4:0]           ts_hour,
  output logic [8:0]           ts_day,
  output logic [6:0]           ts_year,
  output logic [SBS_WIDTH-1:0] ts_sec_day,
  output logic [5:0]           ts_error,
  output logic                 ts_overrun
);
  // Handshake: ts_valid stays high with stable outputs until the edge that sees
  // ts_ready=1; a new load on that same edge keeps it high with the new value.
  typedef enum logic {ST_ACC, ST_CHECK} state_t;

  state_t                      state_q, state_d;
  logic [4:0][11:0]            acc_q, acc_d, stg_q, stg_d;
  logic [SBS_WIDTH-1:0]        sbs_acc_q, sbs_acc_d, sbs_stg_q, sbs_stg_d;
  logic                        valid_q, valid_d, overrun_q, overrun_d;
  logic [5:0]                  second_q, minute_q;
  logic [4:0]                  hour_q;
  logic [8:0]                  day_q;
  logic [6:0]                  year_q;
  logic [SBS_WIDTH-1:0]        sec_day_q;
  logic [5:0]                  error_q, err_c;
  logic [2:0]                  fld;
  logic                        bcd_hit, take_finish, load;
  logic [4:0][11:0]            val;
  logic [4:0]                  dig_err;
  logic [31:0]                 sbs_val;

  assign fld         = ts_select - 3'd1;
  assign bcd_hit     = (ts_select >= 3'd1) && (ts_select <= 3'd5) && (digit_idx != 2'd3)
                       && (YEAR_EN || (ts_select != 3'd5));
  assign take_finish = (state_q == ST_ACC) && ts_finish && !ts_abort;
  assign load        = (state_q == ST_CHECK);

  always_comb begin
    acc_d     = acc_q;
    sbs_acc_d = sbs_acc_q;
    stg_d     = stg_q;
    sbs_stg_d = sbs_stg_q;
    state_d   = ST_ACC;
    if (take_finish) begin
      stg_d     = acc_q;
      sbs_stg_d = sbs_acc_q;
      state_d   = ST_CHECK;
    end
    // Abort or an accepted finish clears the accumulators; a coincident strobe is dropped.
    if (ts_abort || take_finish) begin
      acc_d     = '0;
      sbs_acc_d = '0;
    end else if (bit_strobe && !(state_q == ST_ACC && ts_finish)) begin
      if (bcd_hit)
        acc_d[fld][{digit_idx, bit_idx[1:0]}] = acc_q[fld][{digit_idx, bit_idx[1:0]}] | bit_value;
      if (SBS_EN && ts_select == 3'd6)
        for (int i = 0; i < SBS_WIDTH; i++)
          if (bit_idx == 5'(i)) sbs_acc_d[i] = sbs_acc_q[i] | bit_value;
    end
  end

  always_comb begin
    for (int f = 0; f < 5; f++) begin
      dig_err[f] = (stg_q[f][3:0] > 4'd9) || (stg_q[f][7:4] > 4'd9) || (stg_q[f][11:8] > 4'd9);
      val[f]     = 12'(stg_q[f][3:0]) + 12'(stg_q[f][7:4]) * 12'd10 + 12'(stg_q[f][11:8]) * 12'd100;
    end
    sbs_val  = 32'(sbs_stg_q);
    err_c[0] = dig_err[0] || (val[0] > 12'd59);
    err_c[1] = dig_err[1] || (val[1] > 12'd59);
    err_c[2] = dig_err[2] || (val[2] > 12'd23);
    err_c[3] = dig_err[3] || (val[3] == 12'd0) || (val[3] > 12'd366);
    err_c[4] = YEAR_EN && (dig_err[4] || (stg_q[4][11:8] != 4'd0));
    err_c[5] = SBS_EN && (sbs_val > 32'd86399);
    valid_d   = load ? 1'b1 : (ts_ready ? 1'b0 : valid_q);
    overrun_d = load && valid_q && !ts_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ACC;
      acc_q     <= '0;
      stg_q     <= '0;
      sbs_acc_q <= '0;
      sbs_stg_q <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      second_q  <= '0;
      minute_q  <= '0;
      hour_q    <= '0;
      day_q     <= '0;
      year_q    <= '0;
      sec_day_q <= '0;
      error_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      stg_q     <= stg_d;
      sbs_acc_q <= sbs_acc_d;
      sbs_stg_q <= sbs_stg_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      if (load) begin
        second_q  <= val[0][5:0];
        minute_q  <= val[1][5:0];
        hour_q    <= val[2][4:0];
        day_q     <= val[3][8:0];
        year_q    <= YEAR_EN ? val[4][6:0] : 7'd0;
        sec_day_q <= SBS_EN ? sbs_stg_q : '0;
        error_q   <= err_c;
      end
    end
  end

  assign ts_valid   = valid_q;
  assign ts_overrun = overrun_q;
  assign ts_second  = second_q;
  assign ts_minute  = minute_q;
  assign ts_hour    = hour_q;
  assign ts_day     = day_q;
  assign ts_year    = year_q;
  assign ts_sec_day = sec_day_q;
  assign ts_error   = error_q;
endmodule
